// File: rtl/etapa_ejecucion.sv
// etapa_ejecucion: single-cycle ALU execute stage with 32-cycle shift-add multiplier and register-file write port
module etapa_ejecucion #(
  parameter logic WA0_PROTECT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  wa_in,
  output logic        WE,
  output logic [4:0]  WA,
  output logic [31:0] WD,
  output logic        zero
);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state;
  logic [31:0] ma, mb, prod, part, res;
  logic [4:0] cnt, mwa;
  logic acc, is_mul, nop;
  assign in_ready = (state == IDLE) && rst_n;
  assign acc = in_valid && in_ready;
  assign is_mul = op == 4'd10;
  assign nop = op > 4'd10;
  assign part = prod + (mb[cnt] ? ma << cnt : 32'd0);
  always_comb begin
    res = 32'd0;
    case (op)
      4'd0: res = a + b;
      4'd1: res = a - b;
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = {31'd0, $signed(a) < $signed(b)};
      4'd6: res = a << b[4:0];
      4'd7: res = a >> b[4:0];
      4'd8: res = 32'($signed(a) >>> b[4:0]);
      4'd9: res = ~(a | b);
      default: res = 32'd0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 5'd0;
      WE <= 1'b0;
      WA <= 5'd0;
      WD <= 32'd0;
      zero <= 1'b0;
      ma <= 32'd0;
      mb <= 32'd0;
      prod <= 32'd0;
      mwa <= 5'd0;
    end else begin
      WE <= 1'b0;
      if (state == MUL) begin
        prod <= part;
        cnt <= cnt + 5'd1;
        if (cnt == 5'd31) begin
          state <= IDLE;
          WE <= !(WA0_PROTECT && mwa == 5'd0);
          WA <= mwa;
          WD <= part;
          zero <= part == 32'd0;
        end
      end else if (acc && is_mul) begin
        state <= MUL;
        ma <= a;
        mb <= b;
        mwa <= wa_in;
        prod <= 32'd0;
        cnt <= 5'd0;
      end else if (acc && !nop) begin
        WE <= !(WA0_PROTECT && wa_in == 5'd0);
        WA <= wa_in;
        WD <= res;
        zero <= res == 32'd0;
      end
    end
  end
endmodule

// File: tb/tb_etapa_ejecucion.sv
// tb_etapa_ejecucion: directed and random checks of the execute stage against a transaction-level model
module tb_etapa_ejecucion;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [3:0] op = 4'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic [4:0] wa_in = 5'd0;
  logic in_ready, WE, zero, in_ready0, WE0, zero0;
  logic [4:0] WA, WA0;
  logic [31:0] WD, WD0;
  int n_vec = 0, n_err = 0, mul_left = 0, pulses;
  logic fire = 1'b0, e_zero = 1'b0;
  logic [4:0] e_wa = 5'd0, p_wa = 5'd0;
  logic [31:0] e_wd = 32'd0, p_res = 32'd0, hold;
  always #5 clk = ~clk;
  etapa_ejecucion dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .wa_in(wa_in), .WE(WE), .WA(WA), .WD(WD), .zero(zero));
  etapa_ejecucion #(.WA0_PROTECT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .op(op), .a(a), .b(b), .wa_in(wa_in), .WE(WE0), .WA(WA0), .WD(WD0), .zero(zero0));
  function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int sh;
    sh = int'(y % 32);
    case (o)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return x & y;
      4'd3: return x | y;
      4'd4: return x ^ y;
      4'd5: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6: return x << sh;
      4'd7: return x >> sh;
      4'd8: return x[31] ? ~((~x) >> sh) : x >> sh;
      4'd9: return ~(x | y);
      default: return x * y;
    endcase
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic complete(input logic [4:0] w, input logic [31:0] d);
    fire = 1'b1;
    e_wa = w;
    e_wd = d;
    e_zero = d == 32'd0;
  endtask
  task automatic step(input logic v, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [4:0] w, input logic r);
    rst_n = r;
    in_valid = v;
    op = o;
    a = x;
    b = y;
    wa_in = w;
    #1;
    check("in_ready", in_ready, r && mul_left == 0);
    @(posedge clk);
    fire = 1'b0;
    if (!r) begin
      mul_left = 0;
      e_wa = 5'd0;
      e_wd = 32'd0;
      e_zero = 1'b0;
    end else if (mul_left > 0) begin
      mul_left--;
      if (mul_left == 0) complete(p_wa, p_res);
    end else if (v && o == 4'd10) begin
      mul_left = 32;
      p_res = x * y;
      p_wa = w;
    end else if (v && o < 4'd10) complete(w, ref_alu(o, x, y));
    @(negedge clk);
    check("WE", WE, fire && e_wa != 5'd0);
    check("WE_noprot", WE0, fire);
    check("WA", WA, e_wa);
    check("WD", WD, e_wd);
    check("zero", zero, e_zero);
  endtask
  task automatic idle();
    step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);
  endtask
  initial begin
    step(1'b1, 4'd0, 32'd9, 32'd9, 5'd9, 1'b0);
    step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    check("rst_WD", WD, 32'd0);
    step(1'b1, 4'd0, 32'd5, 32'd7, 5'd3, 1'b1);
    check("add_WE", WE, 1);
    check("add_WA", WA, 3);
    check("add_WD", WD, 12);
    check("add_zero", zero, 0);
    idle();
    check("add_WE_off", WE, 0);
    step(1'b1, 4'd1, 32'd7, 32'd7, 5'd4, 1'b1);
    check("sub_WD", WD, 0);
    check("sub_zero", zero, 1);
    step(1'b1, 4'd5, 32'hFFFFFFFF, 32'd1, 5'd5, 1'b1);
    check("slt_WD", WD, 1);
    check("slt_zero", zero, 0);
    step(1'b1, 4'd10, 32'hFFFFFFFF, 32'd3, 5'd6, 1'b1);
    pulses = 0;
    for (int i = 0; i < 33; i++) begin
      step(i < 32, 4'd0, $urandom, $urandom, 5'd1, 1'b1);
      if (WE) pulses++;
    end
    check("mul_pulses", pulses, 1);
    check("mul_WA", WA, 6);
    check("mul_WD", WD, 32'hFFFFFFFD);
    step(1'b1, 4'd10, $urandom, $urandom, 5'd7, 1'b1);
    repeat (10) idle();
    step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    step(1'b1, 4'd0, 32'd1, 32'd1, 5'd2, 1'b1);
    check("post_rst_WD", WD, 2);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (WE) pulses++;
    end
    check("abort_pulses", pulses, 0);
    step(1'b1, 4'd0, 32'd1, 32'd2, 5'd0, 1'b1);
    check("wa0_WE", WE, 0);
    check("wa0_WE_noprot", WE0, 1);
    check("wa0_WD", WD, 3);
    step(1'b1, 4'd8, 32'h80000000, 32'd4, 5'd8, 1'b1);
    check("sra_WD", WD, 32'hF8000000);
    step(1'b1, 4'd7, 32'h80000000, 32'd4, 5'd8, 1'b1);
    check("srl_WD", WD, 32'h08000000);
    hold = WD;
    step(1'b1, 4'd13, 32'd3, 32'd3, 5'd11, 1'b1);
    check("nop_WE", WE, 0);
    check("nop_WD", WD, hold);
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 7) == 0 ? 32'd0 : $urandom,
           $urandom_range(0, 7) == 0 ? 32'($urandom_range(0, 40)) : $urandom,
           $urandom_range(0, 4) == 0 ? 5'd0 : 5'($urandom), $urandom_range(0, 60) != 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/etapa_ejecucion.md
ETAPA_EJECUCION -- requirements
Module: etapa_ejecucion

Interface
REQ-001 SHALL have parameter: WA0_PROTECT, 1, when 1 any result targeting register 0 is computed but not written (WE held 0).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operation presented this cycle.
REQ-005 SHALL have port: in_ready  output  1  stage can accept an operation this cycle.
REQ-006 SHALL have port: op  input  4  operation code.
REQ-007 SHALL have port: a  input  32  operand A, from register-file read port 1.
REQ-008 SHALL have port: b  input  32  operand B, from register-file read port 2.
REQ-009 SHALL have port: wa_in  input  5  destination register index.
REQ-010 SHALL have port: WE  output  1  register-file write enable, one-cycle pulse per result.
REQ-011 SHALL have port: WA  output  5  register-file write address.
REQ-012 SHALL have port: WD  output  32  register-file write data.
REQ-013 SHALL have port: zero  output  1  1 when WD==0, valid with WE.

Function
REQ-014 SHALL accept an operation on a rising edge where in_valid=1 and in_ready=1; op, a, b, wa_in SHALL be latched only then and ignored otherwise.
REQ-015 SHALL implement states IDLE and MUL; in_ready=1 exactly when state==IDLE and rst_n=1.
REQ-016 SHALL decode op: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed, result 1/0), 0110 SLL by b[4:0], 0111 SRL by b[4:0], 1000 SRA by b[4:0], 1001 NOR, 1010 MUL, 1011-1111 NOP.
REQ-017 SHALL use modulo-2^32 arithmetic for ADD/SUB/MUL; MUL result is the low 32 bits of the unsigned product.
REQ-018 SHALL, for non-MUL ops accepted at edge N, drive WE/WA/WD/zero from registers valid in cycle N+1 for exactly one cycle; state stays IDLE.
REQ-019 SHALL sustain one non-MUL operation per cycle with back-to-back acceptance and no bubbles.
REQ-020 SHALL, for MUL accepted at edge N, enter MUL and compute by shift-add, one multiplier bit per cycle, using a 5-bit counter 0..31 during cycles N+1..N+32.
REQ-021 SHALL, at the edge ending cycle N+32, return to IDLE and register the MUL result; WE=1 in cycle N+33, in_ready=0 during cycles N+1..N+32 and 1 from N+33.
REQ-022 SHALL treat NOP as accepted with WE=0 in cycle N+1; WA/WD hold their previous values.
REQ-023 SHALL, when WA0_PROTECT=1 and wa_in==0, keep WE=0 for that result while still updating WA, WD and zero.
REQ-024 SHALL keep WE=0 in every cycle without a completing operation; WA, WD, zero hold last values.
REQ-025 SHALL compute zero from the registered result, asserted in the same cycle as WE.

Reset
REQ-026 SHALL, on any edge with rst_n=0, set state=IDLE, counter=0, WE=0, WA=0, WD=0, zero=0; in_ready=0 while rst_n=0.
REQ-027 SHALL, when reset hits mid-MUL, abort the operation with no write ever issued for it.
REQ-028 SHALL accept an operation on the first edge where rst_n=1 and in_valid=1.

Verification
REQ-029 SHALL verify ADD a=5 b=7 wa_in=3 -> next cycle WE=1 WA=3 WD=12 zero=0; following cycle WE=0.
REQ-030 SHALL verify SUB a=7 b=7 wa_in=4 then SLT a=0xFFFFFFFF b=1 wa_in=5 back-to-back -> WD=0 zero=1, then WD=1 zero=0 on consecutive cycles.
REQ-031 SHALL verify MUL a=0xFFFFFFFF b=3 wa_in=6 -> in_ready=0 for 32 cycles, WE=1 WA=6 WD=0xFFFFFFFD in cycle N+33, exactly one pulse.
REQ-032 SHALL verify rst_n=0 during MUL counter=10 -> WE never asserts for it; after release in_ready=1 and ADD a=1 b=1 gives WD=2.
REQ-033 SHALL verify ADD a=1 b=2 wa_in=0 with WA0_PROTECT=1 -> WE=0, WD=3; with WA0_PROTECT=0 -> WE=1.
REQ-034 SHALL verify SRA a=0x80000000 b=4 -> WD=0xF8000000; SRL same operands -> WD=0x08000000.
